// File: rtl/hp35_display_capture.sv
// Captures HP-35 ARC display frames (START + NDIG digit strobes) into a shadow
// buffer and publishes each completed frame atomically to a readable visible buffer.
module hp35_display_capture #(
  parameter int NDIG        = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic       osc_in,
  input  logic       cdiv_rst,
  input  logic       phi2_in,
  input  logic [4:0] DD,
  input  logic       START,
  input  logic       clr,
  input  logic [3:0] rd_addr,
  output logic [4:0] rd_data,
  output logic       frame_valid,
  output logic       err_short,
  output logic [7:0] frame_cnt,
  output logic [1:0] dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL   = 2'b01,
    COMMIT = 2'b10
  } state_t;

  localparam logic [4:0] BLANK = 5'b11111;
  localparam int         IW    = (NDIG > 1) ? $clog2(NDIG) : 1;

  state_t          state, state_n;
  logic [IW-1:0]   idx, idx_n, wr_idx;
  logic            shadow_we, discard, set_err, commit;

  logic [SYNC_STAGES-1:0] phi2_sync, start_sync;
  logic [4:0]             dd_sync [SYNC_STAGES];
  logic                   phi2_prev;
  logic                   phi2_s, start_s, strobe;
  logic [4:0]             dd_s;

  logic                   pend_v, pend_start;
  logic [4:0]             pend_dd;
  logic                   eff_stb, eff_start;
  logic [4:0]             eff_dd;

  logic [4:0] shadow  [NDIG];
  logic [4:0] visible [NDIG];

  // phi2 is sampled as data; DD and START use the same depth so they stay aligned.
  // NOTE: sequential state uses non-blocking assignments so every flop sees pre-edge values.
  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      phi2_sync  <= '0;
      start_sync <= '0;
      phi2_prev  <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) dd_sync[i] <= 5'd0;
    end else begin
      phi2_sync[0]  <= phi2_in;
      start_sync[0] <= START;
      dd_sync[0]    <= DD;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        phi2_sync[i]  <= phi2_sync[i-1];
        start_sync[i] <= start_sync[i-1];
        dd_sync[i]    <= dd_sync[i-1];
      end
      phi2_prev <= phi2_sync[SYNC_STAGES-1];
    end
  end

  assign phi2_s  = phi2_sync[SYNC_STAGES-1];
  assign start_s = start_sync[SYNC_STAGES-1];
  assign dd_s    = dd_sync[SYNC_STAGES-1];
  assign strobe  = phi2_prev & ~phi2_s;

  // A strobe landing in COMMIT is replayed in the following (IDLE) cycle.
  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      pend_v     <= 1'b0;
      pend_start <= 1'b0;
      pend_dd    <= 5'd0;
    end else begin
      pend_v     <= (state == COMMIT) && strobe;
      pend_start <= start_s;
      pend_dd    <= dd_s;
    end
  end

  assign eff_stb   = strobe | pend_v;
  assign eff_start = pend_v ? pend_start : start_s;
  assign eff_dd    = pend_v ? pend_dd : dd_s;

  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
    end
  end

  // NOTE: every combinational output gets a default first so no path infers a latch.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    wr_idx    = idx;
    shadow_we = 1'b0;
    discard   = 1'b0;
    set_err   = 1'b0;
    unique case (state)
      IDLE: begin
        if (eff_stb && eff_start) begin
          shadow_we = 1'b1;
          wr_idx    = '0;
          idx_n     = IW'(1);
          state_n   = (NDIG == 1) ? COMMIT : FILL;
        end
      end
      FILL: begin
        if (eff_stb && eff_start) begin
          shadow_we = 1'b1;
          discard   = 1'b1;
          set_err   = 1'b1;
          wr_idx    = '0;
          idx_n     = IW'(1);
        end else if (eff_stb) begin
          shadow_we = 1'b1;
          if (idx == IW'(NDIG - 1)) begin
            idx_n   = '0;
            state_n = COMMIT;
          end else begin
            idx_n = idx + IW'(1);
          end
        end
      end
      COMMIT:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    commit    = (state == COMMIT);
    dbg_state = state;
  end

  // NOTE: the digit buffers are reset because blank (5'b11111) is a visible, required value.
  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      for (int i = 0; i < NDIG; i++) shadow[i] <= BLANK;
    end else if (shadow_we) begin
      if (discard) begin
        for (int i = 0; i < NDIG; i++) shadow[i] <= BLANK;
      end
      shadow[wr_idx] <= eff_dd;
    end
  end

  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      for (int i = 0; i < NDIG; i++) visible[i] <= BLANK;
    end else if (commit) begin
      for (int i = 0; i < NDIG; i++) visible[i] <= shadow[i];
    end
  end

  // Reading old visible contents in the commit cycle gives the pre-update value.
  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      rd_data <= BLANK;
    end else if (int'(rd_addr) >= NDIG) begin
      rd_data <= BLANK;
    end else begin
      rd_data <= visible[rd_addr];
    end
  end

  // Set events take priority over a coincident clr.
  always_ff @(posedge osc_in or posedge cdiv_rst) begin
    if (cdiv_rst) begin
      frame_valid <= 1'b0;
      err_short   <= 1'b0;
      frame_cnt   <= 8'd0;
    end else begin
      frame_valid <= commit  | (frame_valid & ~clr);
      err_short   <= set_err | (err_short & ~clr);
      if (commit) frame_cnt <= frame_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_hp35_display_capture.sv
// Self-checking bench for hp35_display_capture: directed tables, hand sequences
// for commit/reset corners, and random frames against a frame-level model.
module tb_hp35_display_capture;

  localparam int NDIG = 15;
  localparam logic [1:0] S_IDLE = 2'b00, S_FILL = 2'b01, S_COMMIT = 2'b10;

  logic       osc_in = 1'b0;
  logic       cdiv_rst, phi2_in, START, clr;
  logic [4:0] DD;
  logic [3:0] rd_addr;
  logic [4:0] rd_data;
  logic       frame_valid, err_short;
  logic [7:0] frame_cnt;
  logic [1:0] dbg_state;

  hp35_display_capture #(.NDIG(NDIG), .SYNC_STAGES(2)) dut (
    .osc_in(osc_in), .cdiv_rst(cdiv_rst), .phi2_in(phi2_in), .DD(DD),
    .START(START), .clr(clr), .rd_addr(rd_addr), .rd_data(rd_data),
    .frame_valid(frame_valid), .err_short(err_short),
    .frame_cnt(frame_cnt), .dbg_state(dbg_state)
  );

  always #5 osc_in = ~osc_in;

  int checks = 0;
  int failures = 0;

  // Frame-level reference model: a frame is START plus NDIG-1 further digits.
  bit         mdl_busy;
  logic [4:0] mdl_q[$];
  logic [4:0] mdl_vis[NDIG];
  logic       mdl_fv, mdl_err;
  logic [7:0] mdl_cnt;

  typedef struct {
    bit         start;
    logic [4:0] dd;
    logic [1:0] exp_state;
    logic       exp_fv;
  } vec_t;
  vec_t vecs[NDIG];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    mdl_busy = 0;
    mdl_q.delete();
    for (int i = 0; i < NDIG; i++) mdl_vis[i] = 5'h1f;
    mdl_fv  = 0;
    mdl_err = 0;
    mdl_cnt = 0;
  endtask

  task automatic model_strobe(input bit st, input logic [4:0] d);
    if (st) begin
      if (mdl_busy) mdl_err = 1;
      mdl_q.delete();
      mdl_q.push_back(d);
      mdl_busy = 1;
    end else if (mdl_busy) begin
      mdl_q.push_back(d);
    end
    if (mdl_busy && mdl_q.size() == NDIG) begin
      for (int i = 0; i < NDIG; i++) mdl_vis[i] = mdl_q[i];
      mdl_fv   = 1;
      mdl_cnt  = mdl_cnt + 8'd1;
      mdl_busy = 0;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge osc_in);
  endtask

  // Drive one phi2 pulse up to its falling edge; the model sees the strobe now.
  task automatic fall(input bit st, input logic [4:0] d);
    START   = st;
    DD      = d;
    phi2_in = 1'b1;
    tick(4);
    phi2_in = 1'b0;
    model_strobe(st, d);
  endtask

  task automatic strobe(input bit st, input logic [4:0] d);
    fall(st, d);
    tick(4);
  endtask

  task automatic wait_state(input logic [1:0] s, input string name);
    int n = 0;
    while (dbg_state !== s && n < 20) begin
      tick(1);
      n++;
    end
    check(name, dbg_state, s);
  endtask

  task automatic read_check(input string name, input int a);
    rd_addr = 4'(a);
    tick(1);
    check(name, rd_data, (a >= NDIG) ? 5'h1f : mdl_vis[a]);
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_fv"},  frame_valid, mdl_fv);
    check({tag, "_err"}, err_short,   mdl_err);
    check({tag, "_cnt"}, frame_cnt,   mdl_cnt);
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    mdl_fv  = 0;
    mdl_err = 0;
  endtask

  task automatic full_frame();
    strobe(1'b1, 5'($urandom));
    for (int i = 1; i < NDIG; i++) strobe(1'b0, 5'($urandom));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [4:0] old3;
    cdiv_rst = 1'b1;
    phi2_in  = 1'b0;
    START    = 1'b0;
    DD       = 5'd0;
    clr      = 1'b0;
    rd_addr  = 4'd0;
    model_reset();
    for (int i = 0; i < NDIG; i++)
      vecs[i] = '{start: (i == 0), dd: 5'(i),
                  exp_state: (i == NDIG - 1) ? S_IDLE : S_FILL, exp_fv: (i == NDIG - 1)};

    tick(3);
    check("rst_rd_data", rd_data, 5'h1f);
    check("rst_state", dbg_state, S_IDLE);
    check_flags("rst");
    cdiv_rst = 1'b0;
    tick(2);

    // Out-of-range read and strobes with no START before any frame.
    read_check("rd_addr15", 15);
    for (int i = 0; i < 3; i++) strobe(1'b0, 5'($urandom));
    check("nostart_state", dbg_state, S_IDLE);
    check("nostart_fv", frame_valid, 1'b0);

    // First frame: digits 0..14.
    for (int i = 0; i < NDIG; i++) begin
      strobe(vecs[i].start, vecs[i].dd);
      check($sformatf("vec%0d_state", i), dbg_state, vecs[i].exp_state);
      check($sformatf("vec%0d_fv", i), frame_valid, vecs[i].exp_fv);
    end
    check("frame1_cnt", frame_cnt, 8'd1);
    for (int k = 0; k < 16; k++) begin
      rd_addr = 4'(k);
      tick(1);
      check($sformatf("frame1_rd%0d", k), rd_data, (k < NDIG) ? 5'(k) : 5'h1f);
    end

    // Frame restarted by START at slot 7.
    strobe(1'b1, 5'h10);
    for (int i = 1; i < 7; i++) strobe(1'b0, 5'(5'h10 + i));
    strobe(1'b1, 5'h05);
    check("abort_err", err_short, 1'b1);
    check("abort_state", dbg_state, S_FILL);
    check_flags("abort");
    read_check("abort_rd2", 2);
    read_check("abort_rd9", 9);
    for (int i = 1; i < NDIG; i++) strobe(1'b0, 5'(5'h05 + i));
    check_flags("after_abort");
    for (int k = 0; k < NDIG; k++) read_check($sformatf("after_abort_rd%0d", k), k);

    // Read slot 3 continuously across a commit that changes it to 5'h19.
    strobe(1'b1, 5'h01);
    for (int i = 1; i < NDIG - 1; i++) strobe(1'b0, (i == 3) ? 5'h19 : 5'($urandom));
    rd_addr = 4'd3;
    tick(1);
    old3 = mdl_vis[3];
    fall(1'b0, 5'h0a);
    wait_state(S_COMMIT, "hold_commit_seen");
    check("hold_in_commit", rd_data, old3);
    tick(1);
    check("hold_after_commit", rd_data, old3);
    tick(1);
    check("new_value", rd_data, 5'h19);
    tick(3);
    check_flags("hold");

    // Random frames, aborts, stray strobes and clr pulses against the model.
    for (int f = 0; f < 20; f++) begin
      if ($urandom_range(0, 3) == 0) pulse_clr();
      if ($urandom_range(0, 3) == 0) strobe(1'b0, 5'($urandom));
      if ($urandom_range(0, 3) == 0) begin
        int k = $urandom_range(1, NDIG - 2);
        strobe(1'b1, 5'($urandom));
        for (int i = 1; i < k; i++) strobe(1'b0, 5'($urandom));
      end
      full_frame();
      check_flags($sformatf("rnd%0d", f));
      for (int r = 0; r < 3; r++)
        read_check($sformatf("rnd%0d_rd", f), $urandom_range(0, 15));
    end

    // Reset at slot 10 of a frame.
    strobe(1'b1, 5'h03);
    for (int i = 1; i < 10; i++) strobe(1'b0, 5'($urandom));
    fall(1'b0, 5'h0c);
    tick(1);
    cdiv_rst = 1'b1;
    model_reset();
    tick(2);
    check("midrst_state", dbg_state, S_IDLE);
    check("midrst_rd_data", rd_data, 5'h1f);
    check_flags("midrst");
    cdiv_rst = 1'b0;
    tick(2);
    for (int i = 0; i < 4; i++) strobe(1'b0, 5'($urandom));
    check("postrst_state", dbg_state, S_IDLE);
    check_flags("postrst");
    read_check("postrst_rd0", 0);
    read_check("postrst_rd14", 14);

    // 256 frames: counter wraps to zero, frame_valid stays set.
    for (int f = 0; f < 256; f++) begin
      full_frame();
      if (f == 254) check("wrap_cnt255", frame_cnt, 8'd255);
    end
    check("wrap_cnt0", frame_cnt, 8'd0);
    check("wrap_fv", frame_valid, 1'b1);
    check_flags("wrap");

    // clr alone clears; clr coinciding with COMMIT loses to the set.
    pulse_clr();
    tick(1);
    check("clr_fv", frame_valid, 1'b0);
    check("clr_cnt_kept", frame_cnt, mdl_cnt);
    strobe(1'b1, 5'($urandom));
    for (int i = 1; i < NDIG - 1; i++) strobe(1'b0, 5'($urandom));
    fall(1'b0, 5'($urandom));
    wait_state(S_COMMIT, "clr_commit_seen");
    clr = 1'b1;
    tick(1);
    clr = 1'b0;
    tick(3);
    check("clr_commit_fv", frame_valid, 1'b1);
    check_flags("clr_commit");
    for (int k = 0; k < NDIG; k++) read_check($sformatf("final_rd%0d", k), k);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hp35_display_capture.md
HP35_DISPLAY_CAPTURE -- requirements
Module: hp35_display_capture

Interface
REQ-001 SHALL have parameter NDIG, default 15: number of digit slots per display frame.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: synchronizer depth on phi2, START and DD.
REQ-003 SHALL have port osc_in, input, 1: sole clock, rising edge.
REQ-004 SHALL have port cdiv_rst, input, 1: asynchronous, active-high reset.
REQ-005 SHALL have port phi2_in, input, 1: core phase-2 clock, active-low pulse, treated as data.
REQ-006 SHALL have port DD, input, 5: display bus from ARC; [3:0] digit code, [4] decimal-point flag.
REQ-007 SHALL have port START, input, 1: display frame start from ARC.
REQ-008 SHALL have port clr, input, 1: one-cycle pulse that clears the sticky flags.
REQ-009 SHALL have port rd_addr, input, 4: digit slot to read, 0 = first slot after START.
REQ-010 SHALL have port rd_data, output, 5: committed digit at rd_addr.
REQ-011 SHALL have port frame_valid, output, 1: sticky, at least one frame committed.
REQ-012 SHALL have port err_short, output, 1: sticky, frame aborted by early START.
REQ-013 SHALL have port frame_cnt, output, 8: count of committed frames.
REQ-014 SHALL have port dbg_state, output, 2: current FSM state encoding.

Function
REQ-015 SHALL pass phi2_in, START and DD through SYNC_STAGES flops and detect the phi2 sample strobe on the synchronized 1->0 transition of phi2_in.
REQ-016 SHALL sample synchronized DD and START only in the osc_in cycle in which the strobe is high; all other cycles hold state.
REQ-017 SHALL implement FSM IDLE(00), FILL(01), COMMIT(10).
REQ-018 IDLE: strobe with START=1 -> write DD to shadow slot 0, digit index := 1, go to FILL; strobe with START=0 -> ignored.
REQ-019 FILL: strobe with START=0 -> write DD to shadow slot [index], index += 1; after the write to slot NDIG-1, go to COMMIT.
REQ-020 FILL: strobe with START=1 before slot NDIG-1 is written -> set err_short, discard shadow contents, write DD to slot 0, index := 1, remain in FILL.
REQ-021 COMMIT: lasts exactly one osc_in cycle; copy all NDIG shadow slots to the visible buffer in that cycle, set frame_valid, increment frame_cnt, then go to IDLE.
REQ-022 frame_cnt SHALL wrap from 255 to 0.
REQ-023 A strobe coinciding with COMMIT SHALL be evaluated as in IDLE in the following cycle; the strobe spacing of at least 8 osc_in cycles guarantees no strobe is lost.
REQ-024 rd_data SHALL be registered with 1-cycle latency from rd_addr and always reflect the visible buffer only, never a partly filled shadow frame.
REQ-025 rd_addr >= NDIG SHALL return 5'b11111.
REQ-026 A visible-buffer update and a read in the same cycle SHALL return the pre-update value; the new value follows one cycle later.
REQ-027 clr SHALL clear frame_valid and err_short only; if clr coincides with a set event, the set wins.
REQ-028 clr SHALL NOT affect frame_cnt, the buffers or the FSM.

Reset
REQ-029 On cdiv_rst high: state IDLE, index 0, all synchronizer flops 0, shadow and visible slots 5'b11111, rd_data 5'b11111, frame_valid 0, err_short 0, frame_cnt 0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no commit, and the visible buffer SHALL return to blank.
REQ-031 After reset release, a frame SHALL be accepted only from the next strobe at which START=1.

Verification
REQ-032 Reset, then one full frame: START at digit 0, DD = 5'h00..5'h0E across the 15 strobes -> frame_valid=1, frame_cnt=1, rd_addr=k returns k one cycle later.
REQ-033 Frame aborted by START at the strobe for slot 7 -> err_short=1, frame_cnt unchanged, visible buffer unchanged; the next complete frame commits normally.
REQ-034 Read slot 3 continuously while a new frame with slot3=5'h19 commits -> old value is held until the cycle after COMMIT, then 5'h19.
REQ-035 256 complete frames -> frame_cnt wraps to 0 and frame_valid stays 1; clr pulsed together with a COMMIT -> frame_valid stays 1.
REQ-036 Assert cdiv_rst at slot 10 of a frame -> all outputs return to reset values; DD strobes without START are then ignored.
REQ-037 rd_addr=15 -> rd_data=5'b11111; strobes without any START before the first frame -> state stays IDLE and frame_valid=0.
